fifo_burst_reader: RTL and testbench

Read-side consumer for the dual-clock FIFO. It sits in the FIFO's read-clock domain, drives `rinc`, and repackages the FIFO stream into fixed-length bursts of `BURST_LEN` words on a registered valid/ready output. A flush request drains the FIFO completely, padding the final partial burst to full length. The FIFO's `rdata`/`rempty`/`almost_empty` connect directly to this block; its `rinc` comes from here.

---
 rtl/fifo_burst_reader.sv | 162 ++++++++++++++++
 tb/tb_fifo_burst_reader.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader
//   Read-side consumer for the dual-clock FIFO. Pops words from the FIFO and
//   repackages them into fixed bursts of BURST_LEN words on a registered
//   valid/ready output. A flush request drains the FIFO completely and pads
//   the final partial burst with PAD_VALUE up to full length.
//
// Parameters
//   DATASIZE  : word width, must match the FIFO
//   BURST_LEN : words per burst (>= 2, <= FIFO ALMOST_GAP + 1)
//   PAD_VALUE : data emitted in pad slots
//
// Ports
//   clk               in  : FIFO read clock
//   rst_n             in  : asynchronous active-low reset
//   fifo_rdata        in  : FIFO head word, valid while fifo_rempty = 0
//   fifo_rempty       in  : FIFO empty (registered by the FIFO)
//   fifo_almost_empty in  : FIFO holds <= ALMOST_GAP words
//   fifo_rinc         out : pop FIFO head this cycle (combinational)
//   flush             in  : one-cycle drain request
//   out_valid         out : output word valid
//   out_data          out : output word
//   out_last          out : final word of a burst (qualified by out_valid)
//   out_pad           out : word is padding (qualified by out_valid)
//   out_ready         in  : downstream accepts the word when out_valid = 1
//   busy              out : burst in progress or output word pending
//   flush_done        out : one-cycle pulse when a flush has completed
module fifo_burst_reader #(
    parameter int unsigned          DATASIZE  = 8,
    parameter int unsigned          BURST_LEN = 4,
    parameter logic [DATASIZE-1:0]  PAD_VALUE = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATASIZE-1:0] fifo_rdata,
    input  logic                fifo_rempty,
    input  logic                fifo_almost_empty,
    output logic                fifo_rinc,
    input  logic                flush,
    output logic                out_valid,
    output logic [DATASIZE-1:0] out_data,
    output logic                out_last,
    output logic                out_pad,
    input  logic                out_ready,
    output logic                busy,
    output logic                flush_done
);

    localparam int unsigned IDXW = $clog2(BURST_LEN);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(BURST_LEN - 1);

    typedef enum logic {
        IDLE,
        BURST
    } state_e;

    state_e              state_q, state_d;
    logic [IDXW-1:0]     idx_q, idx_d;
    logic                pend_q, pend_d;
    logic                valid_q, valid_d;
    logic [DATASIZE-1:0] data_q, data_d;
    logic                last_q, last_d;
    logic                pad_q, pad_d;

    logic slot;
    logic load;
    logic rinc;
    logic done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            pend_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            pad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
            pad_q   <= pad_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        last_d  = last_q;
        pad_d   = pad_q;
        slot    = !valid_q || out_ready;
        load    = 1'b0;
        rinc    = 1'b0;
        done    = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_almost_empty || (pend_q && !fifo_rempty)) begin
                    state_d = BURST;
                    idx_d   = '0;
                end else if (pend_q && fifo_rempty && !valid_q) begin
                    done = 1'b1;
                end
            end
            BURST: begin
                if (slot) begin
                    if (!fifo_rempty) begin
                        rinc   = 1'b1;
                        load   = 1'b1;
                        data_d = fifo_rdata;
                        pad_d  = 1'b0;
                    end else if (pend_q) begin
                        load   = 1'b1;
                        data_d = PAD_VALUE;
                        pad_d  = 1'b1;
                    end
                    // Empty FIFO without a pending flush: stall with idx held.
                end
                if (load) begin
                    last_d = (idx_q == LAST_IDX);
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDXW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        // A new flush request wins over the clear from a completing flush.
        if (flush) begin
            pend_d = 1'b1;
        end else if (done) begin
            pend_d = 1'b0;
        end else begin
            pend_d = pend_q;
        end
    end

    assign fifo_rinc  = rinc;
    assign out_valid  = valid_q;
    assign out_data   = data_q;
    assign out_last   = last_q;
    assign out_pad    = pad_q;
    assign busy       = (state_q == BURST) || valid_q;
    assign flush_done = done;

endmodule

// File: tb/tb_fifo_burst_reader.sv
module tb_fifo_burst_reader;

    localparam int unsigned BL  = 4;
    localparam int unsigned GAP = 3;
    localparam logic [7:0]  PADV = 8'hA5;

    logic       clk;
    logic       rst_n;
    logic [7:0] fifo_rdata;
    logic       fifo_rempty;
    logic       fifo_almost_empty;
    logic       fifo_rinc;
    logic       flush;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_pad;
    logic       out_ready;
    logic       busy;
    logic       flush_done;

    fifo_burst_reader #(
        .DATASIZE (8),
        .BURST_LEN(BL),
        .PAD_VALUE(PADV)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .fifo_rdata       (fifo_rdata),
        .fifo_rempty      (fifo_rempty),
        .fifo_almost_empty(fifo_almost_empty),
        .fifo_rinc        (fifo_rinc),
        .flush            (flush),
        .out_valid        (out_valid),
        .out_data         (out_data),
        .out_last         (out_last),
        .out_pad          (out_pad),
        .out_ready        (out_ready),
        .busy             (busy),
        .flush_done       (flush_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural FIFO: pointer pair over a 256-entry memory, one write port
    // driven by the bench and the read port popped by the DUT.
    logic [7:0]  mem [256];
    int unsigned wr_ptr = 0;
    int unsigned rd_ptr = 0;
    int          pop_cnt = 0;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        fifo_clr;

    assign fifo_rdata        = mem[rd_ptr[7:0]];
    assign fifo_rempty       = (wr_ptr == rd_ptr);
    assign fifo_almost_empty = ((wr_ptr - rd_ptr) <= GAP);

    always @(posedge clk) begin
        if (fifo_clr) begin
            wr_ptr <= 0;
            rd_ptr <= 0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr[7:0]] <= wr_data;
                wr_ptr <= wr_ptr + 1;
            end
            if (fifo_rinc === 1'b1) begin
                rd_ptr  <= rd_ptr + 1;
                pop_cnt <= pop_cnt + 1;
            end
        end
    end

    // Ready driver: 0 = always 1, 1 = random, 2 = pattern 1,0,0,1, else 0.
    int ready_mode = 0;
    int pat_i = 0;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            2: begin
                out_ready = ((pat_i % 4) == 0) || ((pat_i % 4) == 3);
                pat_i = pat_i + 1;
            end
            default: out_ready = 1'b0;
        endcase
    end

    // Recorder: accepted words, their cycles, flush_done pulses and protocol
    // violations (unstable held word, pop while empty or while slot busy).
    logic [9:0] got_q [$];
    int         got_cyc [$];
    int         done_cnt = 0;
    int         done_cyc = 0;
    int         done_size = 0;
    int         viol = 0;
    logic       prev_stall = 1'b0;
    logic [9:0] prev_word = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall && !(out_valid && ({out_pad, out_last, out_data} == prev_word)))
                viol <= viol + 1;
            if (fifo_rinc && (fifo_rempty || (out_valid && !out_ready)))
                viol <= viol + 1;
            if (out_valid && out_ready) begin
                got_q.push_back({out_pad, out_last, out_data});
                got_cyc.push_back(cyc);
            end
            if (flush_done) begin
                done_cnt  <= done_cnt + 1;
                done_cyc  <= cyc;
                done_size <= got_q.size();
            end
            prev_stall <= out_valid && !out_ready;
            prev_word  <= {out_pad, out_last, out_data};
        end else begin
            prev_stall <= 1'b0;
        end
    end

    // Reference model: words in FIFO order, grouped into bursts of BL, the
    // trailing partial burst padded; last marks every BL-th word.
    logic [7:0] model_q [$];
    logic [9:0] exp_q [$];

    function automatic void build_expected();
        int n;
        int total;
        exp_q.delete();
        n = model_q.size();
        total = ((n + int'(BL) - 1) / int'(BL)) * int'(BL);
        for (int k = 0; k < total; k++) begin
            if (k < n)
                exp_q.push_back({1'b0, (k % int'(BL)) == int'(BL) - 1, model_q[k]});
            else
                exp_q.push_back({1'b1, (k % int'(BL)) == int'(BL) - 1, PADV});
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rec();
        got_q.delete();
        got_cyc.delete();
        model_q.delete();
        done_cnt = 0;
        viol = 0;
    endtask

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) begin
            logic [7:0] d;
            d = 8'($urandom);
            model_q.push_back(d);
            wr_en = 1'b1;
            wr_data = d;
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        #2;
        checks++;
        if ({out_valid, out_last, out_pad, busy, flush_done, fifo_rinc} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b expected 000000",
                     {out_valid, out_last, out_pad, busy, flush_done, fifo_rinc});
        end
        checks++;
        if (out_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_data got %h expected 00", out_data);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_burst();
        int p0;
        clear_rec();
        ready_mode = 0;
        p0 = pop_cnt;
        push_words(4);
        for (int k = 0; k < 200 && got_q.size() < 4; k++) tick();
        repeat (5) tick();
        build_expected();
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL single_count got %0d expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL single_word[%0d] got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        for (int i = 1; i < got_cyc.size(); i++) begin
            checks++;
            if (got_cyc[i] - got_cyc[i-1] !== 1) begin
                errors++;
                $display("FAIL single_gap[%0d] got %0d expected 1", i, got_cyc[i] - got_cyc[i-1]);
            end
        end
        checks++;
        if (pop_cnt - p0 !== 4) begin
            errors++;
            $display("FAIL single_pops got %0d expected 4", pop_cnt - p0);
        end
        checks++;
        if (viol !== 0 || done_cnt !== 0) begin
            errors++;
            $display("FAIL single_proto got viol=%0d done=%0d expected 0 0", viol, done_cnt);
        end
    endtask

    task automatic test_backpressure();
        clear_rec();
        pat_i = 0;
        ready_mode = 2;
        push_words(8);
        for (int k = 0; k < 400 && got_q.size() < 8; k++) tick();
        repeat (4) tick();
        ready_mode = 0;
        tick();
        build_expected();
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL bp_count got %0d expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL bp_word[%0d] got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (viol !== 0) begin
            errors++;
            $display("FAIL bp_proto got %0d expected 0", viol);
        end
    endtask

    task automatic test_flush_partial();
        clear_rec();
        ready_mode = 0;
        push_words(2);
        repeat (5) tick();
        checks++;
        if (got_q.size() !== 0) begin
            errors++;
            $display("FAIL partial_early got %0d expected 0", got_q.size());
        end
        pulse_flush();
        for (int k = 0; k < 200 && done_cnt == 0; k++) tick();
        repeat (5) tick();
        build_expected();
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL partial_count got %0d expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL partial_word[%0d] got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (done_cnt !== 1 || done_size !== 4) begin
            errors++;
            $display("FAIL partial_done got cnt=%0d at=%0d expected cnt=1 at=4", done_cnt, done_size);
        end
        checks++;
        if (busy !== 1'b0 || viol !== 0) begin
            errors++;
            $display("FAIL partial_idle got busy=%b viol=%0d expected 0 0", busy, viol);
        end
    endtask

    task automatic test_flush_empty();
        int c;
        clear_rec();
        ready_mode = 0;
        c = cyc;
        pulse_flush();
        repeat (6) tick();
        checks++;
        if (done_cnt !== 1 || done_cyc !== c + 1) begin
            errors++;
            $display("FAIL empty_done got cnt=%0d cyc=%0d expected cnt=1 cyc=%0d", done_cnt, done_cyc, c + 1);
        end
        checks++;
        if (got_q.size() !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL empty_out got words=%0d busy=%b expected 0 0", got_q.size(), busy);
        end
    endtask

    task automatic test_back_to_back();
        clear_rec();
        ready_mode = 0;
        for (int i = 0; i < 9; i++) begin
            logic [7:0] d;
            d = 8'($urandom);
            model_q.push_back(d);
            wr_en = 1'b1;
            wr_data = d;
            flush = (i == 5);
            tick();
        end
        wr_en = 1'b0;
        flush = 1'b0;
        for (int k = 0; k < 300 && done_cnt == 0; k++) tick();
        repeat (5) tick();
        build_expected();
        checks++;
        if (got_q.size() !== 12 || exp_q.size() !== 12) begin
            errors++;
            $display("FAIL b2b_count got %0d expected 12", got_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL b2b_word[%0d] got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        // One IDLE bubble between bursts, back-to-back words inside a burst.
        for (int i = 1; i < got_cyc.size(); i++) begin
            checks++;
            if (got_cyc[i] - got_cyc[i-1] !== ((i % int'(BL) == 0) ? 2 : 1)) begin
                errors++;
                $display("FAIL b2b_gap[%0d] got %0d expected %0d", i,
                         got_cyc[i] - got_cyc[i-1], (i % int'(BL) == 0) ? 2 : 1);
            end
        end
        checks++;
        if (done_cnt !== 1 || done_size !== 12) begin
            errors++;
            $display("FAIL b2b_done got cnt=%0d at=%0d expected cnt=1 at=12", done_cnt, done_size);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++) begin
            int n;
            clear_rec();
            ready_mode = 1;
            n = $urandom_range(0, 13);
            push_words(n);
            repeat ($urandom_range(0, 6)) tick();
            pulse_flush();
            for (int k = 0; k < 600 && done_cnt == 0; k++) tick();
            repeat (3) tick();
            build_expected();
            checks++;
            if (got_q.size() !== exp_q.size()) begin
                errors++;
                $display("FAIL rnd%0d_count got %0d expected %0d", it, got_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL rnd%0d_word[%0d] got %h expected %h", it, i, got_q[i], exp_q[i]);
                end
            end
            checks++;
            if (done_cnt !== 1 || done_size !== exp_q.size() || viol !== 0) begin
                errors++;
                $display("FAIL rnd%0d_done got cnt=%0d at=%0d viol=%0d expected cnt=1 at=%0d viol=0",
                         it, done_cnt, done_size, viol, exp_q.size());
            end
        end
        ready_mode = 0;
        tick();
    endtask

    task automatic test_reset_mid_burst();
        int p0;
        clear_rec();
        ready_mode = 3;
        push_words(5);
        for (int k = 0; k < 50 && out_valid !== 1'b1; k++) tick();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_valid got %b expected 1", out_valid);
        end
        rst_n = 1'b0;
        #2;
        checks++;
        if ({out_valid, out_last, out_pad, busy, flush_done, fifo_rinc} !== 6'b0 || out_data !== 8'h00) begin
            errors++;
            $display("FAIL rstmid_async got ctrl=%b data=%h expected 000000 00",
                     {out_valid, out_last, out_pad, busy, flush_done, fifo_rinc}, out_data);
        end
        fifo_clr = 1'b1;
        tick();
        fifo_clr = 1'b0;
        tick();
        rst_n = 1'b1;
        ready_mode = 0;
        p0 = pop_cnt;
        repeat (10) tick();
        checks++;
        if (pop_cnt !== p0 || got_q.size() !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_after got pops=%0d words=%0d busy=%b expected 0 0 0",
                     pop_cnt - p0, got_q.size(), busy);
        end
    endtask

    initial begin
        wr_en = 1'b0;
        wr_data = '0;
        flush = 1'b0;
        fifo_clr = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_single_burst();
        test_backpressure();
        test_flush_partial();
        test_flush_empty();
        test_back_to_back();
        test_random();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
